// File: rtl/seq_pkg.sv
// Shared definitions for the Y86-64 SEQ stage sequencer: status codes,
// instruction codes, FSM state encoding and the memory-stage predicate.
package seq_pkg;

  // Architectural status codes
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Y86-64 instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Sequencer state encoding (binary, all eight codes used)
  localparam int         STATE_W     = 3;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_PCUPD     = 3'd6;
  localparam logic [2:0] S_HALTED    = 3'd7;

  // True for instructions that touch data memory (loads, stores, stack ops).
  function automatic logic needs_mem(input logic [3:0] icode);
    case (icode)
      IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: needs_mem = 1'b1;
      IHALT, INOP, IRRMOVQ, IIRMOVQ, IOPQ, IJXX:    needs_mem = 1'b0;
      default:                                      needs_mem = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_ctrl_counters.sv
// Retired-instruction and running-cycle counters for the SEQ sequencer.
// Both wrap modulo 2^CNT_W.
module seq_ctrl_counters
  import seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             running_i,   // sequencer is between IDLE and HALTED
  input  logic             retire_i,    // PCUPD cycle: instruction completes at this edge
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  logic [CNT_W-1:0] instr_cnt_q;
  logic [CNT_W-1:0] cycle_cnt_q;

  // Advance the counters on each qualifying edge; wrap without saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (retire_i) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      if (running_i) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
    end
  end

  assign instr_cnt_o = instr_cnt_q;
  assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath. Drives one-hot
// stage enables, stalls MEMORY until data memory responds (with timeout),
// owns the architectural status code and stops on the first fault.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             halt,
  input  logic             i_error,
  input  logic             mem_error,
  input  logic             dmem_error,
  input  logic             mem_ready,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic [1:0]       stat,
  output logic             running,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  logic [STATE_W-1:0] state_q, state_d;
  logic [1:0]         stat_q, stat_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [WAIT_W-1:0]  wait_inc;

  assign wait_inc = wait_q + WAIT_W'(1);

  // Next-state, status and memory-wait logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    stat_d  = stat_q;
    wait_d  = '0;  // only MEMORY holds a nonzero count, so it is clear on entry

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        // Fetch faults in priority order; a faulting instruction never retires.
        if (mem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else if (i_error) begin
          stat_d  = STAT_INS;
          state_d = S_HALTED;
        end else if (halt) begin
          stat_d  = STAT_HLT;
          state_d = S_HALTED;
        end else begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: state_d = S_EXECUTE;

      S_EXECUTE: state_d = needs_mem(icode) ? S_MEMORY : S_WRITEBACK;

      S_MEMORY: begin
        // An address error outranks a simultaneous completion.
        if (dmem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else if (mem_ready) begin
          state_d = S_WRITEBACK;
        end else if (wait_inc == WAIT_LIMIT) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else begin
          wait_d = wait_inc;
        end
      end

      S_WRITEBACK: state_d = S_PCUPD;

      S_PCUPD: state_d = S_FETCH;

      S_HALTED: state_d = S_HALTED;  // only rst leaves this state
    endcase
  end

  // State, status and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      wait_q  <= wait_d;
    end
  end

  // Moore decode of the stage enables and the running flag.
  always_comb begin
    f_en    = 1'b0;
    d_en    = 1'b0;
    e_en    = 1'b0;
    m_en    = 1'b0;
    wb_en   = 1'b0;
    pc_en   = 1'b0;
    running = 1'b1;
    case (state_q)
      S_FETCH:     f_en  = 1'b1;
      S_DECODE:    d_en  = 1'b1;
      S_EXECUTE:   e_en  = 1'b1;
      S_MEMORY:    m_en  = 1'b1;
      S_WRITEBACK: wb_en = 1'b1;
      S_PCUPD:     pc_en = 1'b1;
      default:     running = 1'b0;  // IDLE and HALTED
    endcase
  end

  assign stat = stat_q;

  seq_ctrl_counters #(
    .CNT_W(CNT_W)
  ) u_counters (
    .clk        (clk),
    .rst        (rst),
    .running_i  (running),
    .retire_i   (state_q == S_PCUPD),
    .instr_cnt_o(instr_cnt),
    .cycle_cnt_o(cycle_cnt)
  );

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl. Each instruction is expanded into an
// expected per-cycle stage schedule from the sequencing rules (stage list,
// memory wait length, fault priorities); inputs are driven open-loop from that
// schedule with random noise on every input the current stage must ignore.
module tb_seq_ctrl;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 15;

  localparam logic [1:0] AOK = 2'd0;
  localparam logic [1:0] HLT = 2'd1;
  localparam logic [1:0] ADR = 2'd2;
  localparam logic [1:0] INS = 2'd3;

  // Expected enable patterns as {f, d, e, m, wb, pc}
  localparam logic [5:0] EN_NONE = 6'b000000;
  localparam logic [5:0] EN_F    = 6'b100000;
  localparam logic [5:0] EN_D    = 6'b010000;
  localparam logic [5:0] EN_E    = 6'b001000;
  localparam logic [5:0] EN_M    = 6'b000100;
  localparam logic [5:0] EN_WB   = 6'b000010;
  localparam logic [5:0] EN_PC   = 6'b000001;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       icode;
  logic             halt;
  logic             i_error;
  logic             mem_error;
  logic             dmem_error;
  logic             mem_ready;
  logic             f_en, d_en, e_en, m_en, wb_en, pc_en;
  logic [1:0]       stat;
  logic             running;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  seq_ctrl #(
    .MEM_TIMEOUT(TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .icode     (icode),
    .halt      (halt),
    .i_error   (i_error),
    .mem_error (mem_error),
    .dmem_error(dmem_error),
    .mem_ready (mem_ready),
    .f_en      (f_en),
    .d_en      (d_en),
    .e_en      (e_en),
    .m_en      (m_en),
    .wb_en     (wb_en),
    .pc_en     (pc_en),
    .stat      (stat),
    .running   (running),
    .instr_cnt (instr_cnt),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_err = 0;
  logic [1:0]       exp_stat;
  logic [CNT_W-1:0] exp_instr;
  logic [CNT_W-1:0] exp_cycle;
  bit               aborted;
  bit               halted;
  int               abort_at;
  int               cyc_idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] enables();
    return {f_en, d_en, e_en, m_en, wb_en, pc_en};
  endfunction

  // Randomise every single-bit input; callers then pin the ones that matter.
  task automatic drive_noise();
    {start, halt, i_error, mem_error, dmem_error, mem_ready} = 6'($urandom);
  endtask

  // Assert rst between edges and confirm the outputs clear without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_en",      64'(enables()), 64'(EN_NONE));
    check("rst_running", 64'(running),   64'(0));
    check("rst_stat",    64'(stat),      64'(AOK));
    check("rst_instr",   64'(instr_cnt), 64'(0));
    check("rst_cycle",   64'(cycle_cnt), 64'(0));
    @(negedge clk);
    rst       = 1'b0;
    exp_stat  = AOK;
    exp_instr = '0;
    exp_cycle = '0;
  endtask

  // One clock of the schedule: check the current cycle, then cross the edge.
  task automatic step(input logic [5:0] exp_en);
    if (aborted) return;
    if (cyc_idx == abort_at) begin
      async_reset();
      aborted = 1'b1;
      return;
    end
    check("enables",   64'(enables()), 64'(exp_en));
    check("running",   64'(running),   64'(|exp_en));
    check("stat",      64'(stat),      64'(exp_stat));
    check("instr_cnt", 64'(instr_cnt), 64'(exp_instr));
    check("cycle_cnt", 64'(cycle_cnt), 64'(exp_cycle));
    @(posedge clk);
    if (|exp_en) exp_cycle = exp_cycle + 1'b1;
    if (exp_en == EN_PC) exp_instr = exp_instr + 1'b1;
    @(negedge clk);
    cyc_idx++;
  endtask

  // One instruction. w = mem_ready-low cycles (w >= TIMEOUT means timeout);
  // dm = data-memory fault after w low cycles, dm_rdy = mem_ready alongside it.
  task automatic run_instr(input logic [3:0] ic, input bit me, input bit ie, input bit h,
                           input int w, input bit dm, input bit dm_rdy);
    int lows;
    cyc_idx = 0;
    icode   = ic;

    drive_noise();
    mem_error = me;
    i_error   = ie;
    halt      = h;
    step(EN_F);
    if (aborted) return;
    if (me || ie || h) begin
      exp_stat = me ? ADR : (ie ? INS : HLT);
      halted   = 1'b1;
      return;
    end

    drive_noise(); step(EN_D);
    drive_noise(); step(EN_E);

    if (ic inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11}) begin
      lows = (w >= TIMEOUT) ? TIMEOUT : w;
      for (int i = 0; i < lows; i++) begin
        drive_noise();
        mem_ready  = 1'b0;
        dmem_error = 1'b0;
        step(EN_M);
      end
      if (aborted) return;
      if (w >= TIMEOUT) begin
        exp_stat = ADR;
        halted   = 1'b1;
        return;
      end
      drive_noise();
      dmem_error = dm;
      mem_ready  = dm ? dm_rdy : 1'b1;
      step(EN_M);
      if (aborted) return;
      if (dm) begin
        exp_stat = ADR;
        halted   = 1'b1;
        return;
      end
    end

    drive_noise(); step(EN_WB);
    drive_noise(); step(EN_PC);
  endtask

  // One idle cycle, then a start request taken from IDLE.
  task automatic start_prog();
    aborted = 1'b0;
    halted  = 1'b0;
    drive_noise(); start = 1'b0; step(EN_NONE);
    drive_noise(); start = 1'b1; step(EN_NONE);
  endtask

  // Sit in HALTED hammering start, then leave through reset.
  task automatic finish_halted();
    repeat (3) begin
      drive_noise();
      start = 1'b1;
      step(EN_NONE);
    end
    async_reset();
  endtask

  initial begin
    rst        = 1'b1;
    {start, halt, i_error, mem_error, dmem_error, mem_ready} = '0;
    icode      = '0;
    abort_at   = -1;
    cyc_idx    = 0;
    aborted    = 1'b0;
    halted     = 1'b0;
    exp_stat   = AOK;
    exp_instr  = '0;
    exp_cycle  = '0;

    repeat (2) @(negedge clk);
    check("init_en",    64'(enables()), 64'(EN_NONE));
    check("init_stat",  64'(stat),      64'(AOK));
    check("init_instr", 64'(instr_cnt), 64'(0));
    rst = 1'b0;

    // IDLE must hold while start is low
    repeat (3) begin drive_noise(); start = 1'b0; step(EN_NONE); end

    // opq alone: 5 cycles, one retire (seen at the following halt fetch)
    start_prog();
    run_instr(4'd6, 0, 0, 0, 0, 0, 0);
    run_instr(4'd0, 0, 0, 1, 0, 0, 0);
    finish_halted();

    // mrmovq with three wait cycles: 9 cycles total
    start_prog();
    run_instr(4'd5, 0, 0, 0, 3, 0, 0);
    run_instr(4'd0, 0, 0, 1, 0, 0, 0);
    finish_halted();

    // halt as the third instruction
    start_prog();
    run_instr(4'd6, 0, 0, 0, 0, 0, 0);
    run_instr(4'd3, 0, 0, 0, 0, 0, 0);
    run_instr(4'd0, 0, 0, 1, 0, 0, 0);
    finish_halted();

    // fetch fault priority: ADR over INS, then INS alone
    start_prog(); run_instr(4'd6, 1, 1, 0, 0, 0, 0); finish_halted();
    start_prog(); run_instr(4'd6, 0, 1, 0, 0, 0, 0); finish_halted();

    // call with mem_ready never arriving: timeout
    start_prog(); run_instr(4'd8, 0, 0, 0, TIMEOUT, 0, 0); finish_halted();

    // pushq: dmem_error together with mem_ready
    start_prog(); run_instr(4'd10, 0, 0, 0, 2, 1, 1); finish_halted();

    // longest wait that still completes
    start_prog();
    run_instr(4'd5, 0, 0, 0, TIMEOUT - 1, 0, 0);
    run_instr(4'd0, 0, 0, 1, 0, 0, 0);
    finish_halted();

    // reset in the middle of a memory wait, then a clean restart
    start_prog();
    abort_at = 8;
    run_instr(4'd8, 0, 0, 0, 10, 0, 0);
    abort_at = -1;
    start_prog();
    run_instr(4'd6, 0, 0, 0, 0, 0, 0);
    run_instr(4'd0, 0, 0, 1, 0, 0, 0);
    finish_halted();

    // randomised programs
    for (int p = 0; p < 30; p++) begin
      start_prog();
      for (int k = 0; k < 6 && !halted && !aborted; k++) begin
        logic [3:0] ic;
        bit         me, ie, h, dm;
        int         w;
        ic = 4'($urandom_range(1, 11));
        me = ($urandom_range(0, 15) == 0);
        ie = ($urandom_range(0, 15) == 0);
        h  = ($urandom_range(0, 15) == 0) || (k == 5);
        if (h) ic = 4'd0;
        w  = ($urandom_range(0, 11) == 0) ? TIMEOUT : int'($urandom_range(0, 5));
        dm = ($urandom_range(0, 9) == 0);
        abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 10)) : -1;
        run_instr(ic, me, ie, h, w, dm, 1'($urandom));
        abort_at = -1;
      end
      if (!aborted) finish_halted();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
Name: seq_ctrl

Overview:
Multi-cycle stage sequencer for the Y86-64 SEQ datapath (fetch, decode_wb, execute, memory, pc_update). It replaces free-running combinational stage evaluation with one-hot stage enables, so each instruction advances one stage per clock. It holds the memory stage until data memory acknowledges, and it owns the architectural status code (AOK/HLT/ADR/INS). It stops the machine on the first non-AOK status and keeps retired-instruction and cycle counters for the bench.

Parameters:
MEM_TIMEOUT, 15, maximum MEMORY wait cycles without mem_ready before an ADR fault
CNT_W, 32, width of instr_cnt and cycle_cnt

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  level; sampled only in IDLE; begins execution at current PC
icode  input  4  instruction code from fetch; valid from the FETCH cycle onward
halt  input  1  fetch saw halt (icode 0)
i_error  input  1  fetch saw an invalid icode/ifun
mem_error  input  1  fetch address out of range
dmem_error  input  1  data memory address out of range
mem_ready  input  1  data memory access complete, sampled in MEMORY
f_en  output  1  fetch stage latch enable
d_en  output  1  decode (register read) enable
e_en  output  1  execute/CC update enable
m_en  output  1  data memory access enable
wb_en  output  1  register-file write enable
pc_en  output  1  PC load enable (PC <= PC_u)
stat  output  2  0=AOK, 1=HLT, 2=ADR, 3=INS
running  output  1  high in every state except IDLE and HALTED
instr_cnt  output  CNT_W  instructions retired
cycle_cnt  output  CNT_W  clocks spent with running=1

Behaviour:
- Reset (async, any state, including mid-instruction): state=IDLE, all enables 0, stat=AOK, running=0, counters 0, wait counter 0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED. Enables are a Moore decode of state: exactly one is high in FETCH..PCUPD, and none in IDLE or HALTED.
- IDLE: start=1 -> FETCH on the next edge. Otherwise stay.
- FETCH, evaluated in priority order: mem_error -> stat=ADR, HALTED; i_error -> INS, HALTED; halt -> HLT, HALTED; else DECODE. A faulting instruction causes no WB, PC update or retire.
- DECODE -> EXECUTE.
- EXECUTE -> MEMORY if icode is in {4 rmmovq, 5 mrmovq, 8 call, 9 ret, 10 pushq, 11 popq}; else -> WRITEBACK.
- MEMORY: the wait counter clears on entry and m_en stays high for the whole wait.
  - dmem_error -> ADR, HALTED. dmem_error beats mem_ready in the same cycle.
  - Else mem_ready -> WRITEBACK.
  - Else increment the wait counter; on reaching MEM_TIMEOUT -> ADR, HALTED.
- WRITEBACK -> PCUPD. wb_en is asserted for every icode; decode_wb qualifies the write by icode/Cnd.
- PCUPD -> FETCH; instr_cnt += 1 at this edge. start is ignored outside IDLE.
- HALTED: stat is held, running=0, and the state is left only by rst. All inputs are ignored.
- Latency per instruction: 5 cycles without memory; 6+W cycles with memory, where W is the number of mem_ready-low cycles.
- Counters wrap modulo 2^CNT_W with no saturation. cycle_cnt increments on every edge where running=1, including the faulting cycle.
- stat is registered and changes on the same edge as the transition to HALTED.

Decomposition:
- Shared package seq_pkg:
  - STAT_AOK/HLT/ADR/INS constants.
  - Icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11.
  - State encoding.
- Sub-module: seq_ctrl_counters, holding instr_cnt and cycle_cnt. The FSM stays in seq_ctrl.

Test Plan:
- rst high, then start=1 with icode=6 (opq) and no errors: enables pulse f,d,e,wb,pc on cycles 1-5, no m_en; instr_cnt=1 after cycle 5; cycle_cnt=5.
- icode=5 (mrmovq), mem_ready low for 3 cycles then high: m_en high 4 cycles; total 9 cycles; instr_cnt=1; stat=AOK.
- Fetch with halt=1 on the 3rd instruction: stat=1, running=0, instr_cnt=2, and no wb_en/pc_en for the halt instruction. Later start pulses are ignored.
- In FETCH, i_error=1 and mem_error=1 together: stat=2 (ADR wins). Separately, i_error alone gives stat=3.
- icode=8 (call), mem_ready held low: after 15 wait cycles stat=2 and HALTED. A variant with dmem_error=1 and mem_ready=1 in the same cycle gives stat=2 immediately.
- Assert rst in MEMORY mid-wait: on the same edge (async) all enables 0, stat=0, counters 0, state IDLE. After release, start resumes from FETCH.
